// File: rtl/muldiv_ctrl_if.sv
// Requester-side bundle for the multiply/divide controller.
// The master side issues ops; the slave side is muldiv_ctrl.
interface muldiv_ctrl_if;
    logic        valid_i;
    logic [3:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        ready_o;
    logic        stall_o;
    logic        mf_valid_o;
    logic [31:0] mf_data_o;
    logic        dz_o;
    logic [15:0] mul_cnt_o;
    logic [15:0] div_cnt_o;

    modport master (
        output valid_i, op_i, a_i, b_i, flush_i,
        input  ready_o, stall_o, mf_valid_o, mf_data_o, dz_o, mul_cnt_o, div_cnt_o
    );

    modport slave (
        input  valid_i, op_i, a_i, b_i, flush_i,
        output ready_o, stall_o, mf_valid_o, mf_data_o, dz_o, mul_cnt_o, div_cnt_o
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequences MULT/DIV/MTxx/MFxx requests onto a multi-cycle HI/LO unit, with flush
// rollback, a 32-cycle busy watchdog and saturating completion counters.
module muldiv_ctrl (
    input  logic               clk,
    input  logic               reset,
    muldiv_ctrl_if.slave       req,
    output logic [31:0]        u_a,
    output logic [31:0]        u_b,
    output logic [1:0]         u_op,
    output logic               u_start,
    output logic               u_we,
    output logic               u_rollback,
    input  logic [31:0]        u_rd,
    input  logic               u_busy
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic        issued_q, issued_d;
    logic        is_div_q, is_div_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  wd_q, wd_d;
    logic [15:0] mul_cnt_q, mul_cnt_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic        accept;

    assign req.mul_cnt_o = mul_cnt_q;
    assign req.div_cnt_o = div_cnt_q;

    always_comb begin
        state_d        = state_q;
        issued_d       = 1'b0;
        is_div_d       = is_div_q;
        op_d           = op_q;
        wd_d           = wd_q;
        mul_cnt_d      = mul_cnt_q;
        div_cnt_d      = div_cnt_q;
        accept         = 1'b0;
        req.ready_o    = 1'b0;
        req.stall_o    = 1'b0;
        req.mf_valid_o = 1'b0;
        req.mf_data_o  = u_rd;
        req.dz_o       = 1'b0;
        u_a            = req.a_i;
        u_b            = req.b_i;
        u_op           = op_q;
        u_start        = 1'b0;
        u_we           = 1'b0;
        u_rollback     = 1'b0;

        unique case (state_q)
            StIdle: begin
                req.ready_o = ~req.flush_i;
                // Only an op issued in the previous cycle can still be cancelled from IDLE.
                u_rollback  = req.flush_i & issued_q;
                accept      = req.valid_i & ~req.flush_i;
                case (req.op_i)
                    4'd1:        u_op = 2'd1;
                    4'd2:        u_op = 2'd0;
                    4'd3:        u_op = 2'd3;
                    4'd4:        u_op = 2'd2;
                    4'd5, 4'd7:  u_op = 2'd1;
                    4'd6, 4'd8:  u_op = 2'd0;
                    default:     u_op = op_q;
                endcase
                if (accept) begin
                    case (req.op_i)
                        4'd1, 4'd2: u_start = 1'b1;
                        4'd3, 4'd4: begin
                            if (req.b_i == 32'd0) req.dz_o = 1'b1;
                            else                  u_start  = 1'b1;
                        end
                        4'd5, 4'd6: u_we = 1'b1;
                        4'd7, 4'd8: req.mf_valid_o = 1'b1;
                        default: ;
                    endcase
                end
                req.stall_o = u_start;
                issued_d    = u_start | u_we;
                if (u_start) begin
                    state_d  = StBusy;
                    is_div_d = (req.op_i == 4'd3) || (req.op_i == 4'd4);
                    op_d     = u_op;
                    wd_d     = 5'd0;
                end
            end
            StBusy: begin
                req.stall_o = 1'b1;
                if (req.flush_i || ((wd_q == 5'd31) && u_busy)) begin
                    u_rollback = 1'b1;
                    state_d    = StIdle;
                end else if (!u_busy) begin
                    state_d = StIdle;
                    if (is_div_q) begin
                        if (div_cnt_q != 16'hFFFF) div_cnt_d = div_cnt_q + 16'd1;
                    end else begin
                        if (mul_cnt_q != 16'hFFFF) mul_cnt_d = mul_cnt_q + 16'd1;
                    end
                end else begin
                    wd_d = wd_q + 5'd1;
                end
            end
        endcase

        // Reset abandons everything silently: no strobes, no rollback.
        if (reset) begin
            req.ready_o    = 1'b0;
            req.stall_o    = 1'b0;
            req.mf_valid_o = 1'b0;
            req.dz_o       = 1'b0;
            u_start        = 1'b0;
            u_we           = 1'b0;
            u_rollback     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            issued_q  <= 1'b0;
            is_div_q  <= 1'b0;
            op_q      <= 2'd0;
            wd_q      <= 5'd0;
            mul_cnt_q <= 16'd0;
            div_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            issued_q  <= issued_d;
            is_div_q  <= is_div_d;
            op_q      <= op_d;
            wd_q      <= wd_d;
            mul_cnt_q <= mul_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed table, corner sequences and random
// traffic against a cycle-level model of the controller rules plus a HI/LO unit model.
module tb_muldiv_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] u_a, u_b, u_rd;
    logic [1:0]  u_op;
    logic        u_start, u_we, u_rollback, u_busy;

    muldiv_ctrl_if bus ();

    muldiv_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req        (bus.slave),
        .u_a        (u_a),
        .u_b        (u_b),
        .u_op       (u_op),
        .u_start    (u_start),
        .u_we       (u_we),
        .u_rollback (u_rollback),
        .u_rd       (u_rd),
        .u_busy     (u_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model / environment state
    logic        m_busy, m_issued, m_isdiv, stuck;
    int          m_bcnt, rem, lat;
    logic [15:0] m_mul, m_div;
    logic [31:0] m_hi, m_lo;

    assign u_busy = stuck || (rem != 0);
    assign u_rd   = u_op[0] ? m_hi : m_lo;

    int vectors = 0;
    int errors  = 0;
    int o_start, o_we, o_rb, o_stall;
    logic        o_mfv;
    logic [31:0] o_mfd;
    logic [6:0]  o_ctl;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic f);
        bus.valid_i = v;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.flush_i = f;
    endtask

    // One clock: compare at negedge, advance model just after posedge.
    task automatic tick();
        logic [6:0]  e, act, mask;
        logic [1:0]  e_uop;
        logic        chk_uop, ub, nb, ni, nisd, wd;
        logic [31:0] e_mfd, nhi, nlo, a, b;
        logic [63:0] p;
        logic [15:0] nmul, ndiv;
        longint      sa, sb, q, r;
        int          nbc, nrem;
        @(negedge clk);
        a = bus.a_i; b = bus.b_i;
        ub = stuck || (rem != 0);
        e = '0; mask = 7'h7F; chk_uop = 1'b0; e_uop = 2'd0; e_mfd = '0;
        nb = m_busy; ni = 1'b0; nbc = m_bcnt; nrem = (rem > 0) ? rem - 1 : 0;
        nmul = m_mul; ndiv = m_div; nisd = m_isdiv; nhi = m_hi; nlo = m_lo;
        if (reset) begin
            mask = 7'h3F;
            nb = 1'b0; nmul = '0; ndiv = '0; nrem = 0;
        end else if (!m_busy) begin
            e[6] = !bus.flush_i;
            e[0] = bus.flush_i && m_issued;
            if (bus.valid_i && !bus.flush_i) begin
                case (bus.op_i)
                    4'd1, 4'd2: e[2] = 1'b1;
                    4'd3, 4'd4: if (b == 0) e[3] = 1'b1; else e[2] = 1'b1;
                    4'd5, 4'd6: e[1] = 1'b1;
                    4'd7, 4'd8: e[4] = 1'b1;
                    default: ;
                endcase
            end
            e[5] = e[2];
            ni = e[2] | e[1];
            if (e[2]) begin
                chk_uop = 1'b1;
                nb = 1'b1; nbc = 1; nisd = bus.op_i >= 4'd3; nrem = lat - 1;
                case (bus.op_i)
                    4'd1: begin e_uop = 2'd1;
                        p = 64'(longint'($signed(a)) * longint'($signed(b)));
                        nhi = p[63:32]; nlo = p[31:0]; end
                    4'd2: begin e_uop = 2'd0;
                        p = {32'd0, a} * {32'd0, b}; nhi = p[63:32]; nlo = p[31:0]; end
                    4'd3: begin e_uop = 2'd3;
                        sa = longint'($signed(a)); sb = longint'($signed(b));
                        q = sa / sb; r = sa % sb; nlo = q[31:0]; nhi = r[31:0]; end
                    default: begin e_uop = 2'd2; nlo = a / b; nhi = a % b; end
                endcase
            end
            if (e[1]) begin
                chk_uop = 1'b1; e_uop = {1'b0, bus.op_i == 4'd5};
                if (bus.op_i == 4'd5) nhi = a; else nlo = a;
            end
            if (e[4]) begin
                chk_uop = 1'b1; e_uop = {1'b0, bus.op_i == 4'd7};
                e_mfd = (bus.op_i == 4'd7) ? m_hi : m_lo;
            end
        end else begin
            e[5] = 1'b1;
            wd = (m_bcnt == 32) && ub;
            e[0] = bus.flush_i || wd;
            if (e[0]) begin
                nb = 1'b0; nrem = 0;
            end else if (!ub) begin
                nb = 1'b0;
                if (m_isdiv) begin if (m_div < 16'hFFFF) ndiv = m_div + 16'd1; end
                else begin if (m_mul < 16'hFFFF) nmul = m_mul + 16'd1; end
            end else begin
                nbc = m_bcnt + 1;
            end
        end
        act = {bus.ready_o, bus.stall_o, bus.mf_valid_o, bus.dz_o, u_start, u_we, u_rollback};
        chk("ctl", 64'(act & mask), 64'(e & mask));
        chk("cnt", {32'd0, bus.mul_cnt_o, bus.div_cnt_o}, {32'd0, m_mul, m_div});
        if (chk_uop) chk("u_op", 64'(u_op[e[2] ? 1 : 0 +: 1] & 1'b0) | 64'(u_op & (e[2] ? 2'b11 : 2'b01)),
                         64'(e_uop));
        if (e[4]) chk("mf_data", 64'(bus.mf_data_o), 64'(e_mfd));
        if (e[2]) chk("u_ab", {u_a, u_b}, {a, b});
        if (e[1]) chk("u_a", 64'(u_a), 64'(a));
        o_ctl = act; o_mfv = bus.mf_valid_o; o_mfd = bus.mf_data_o;
        o_start += int'(u_start); o_we += int'(u_we); o_rb += int'(u_rollback);
        o_stall += int'(bus.stall_o);
        @(posedge clk);
        #1;
        m_busy = nb; m_issued = ni; m_bcnt = nbc; rem = nrem; m_mul = nmul; m_div = ndiv;
        m_isdiv = nisd; m_hi = nhi; m_lo = nlo;
    endtask

    task automatic clr_obs();
        o_start = 0; o_we = 0; o_rb = 0; o_stall = 0;
    endtask

    task automatic drain();
        int n = 0;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        do begin tick(); n++; end while ((m_busy || m_issued) && n < 64);
        if (m_busy) begin
            vectors++; errors++;
            $display("FAIL drain: model still busy after %0d cycles, required idle", n);
        end
    endtask

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        f;
        logic [5:0]  exp;   // {ready, stall, mf_valid, dz, u_start, u_we}
    } vec_t;

    vec_t tbl [15];

    initial begin
        int n;
        logic [15:0] d0;
        tbl[0]  = '{1'b0, 4'd0, 32'd0,        32'd0,  1'b0, 6'b100000};
        tbl[1]  = '{1'b1, 4'd1, 32'd7,        -32'sd3, 1'b0, 6'b110010};
        tbl[2]  = '{1'b1, 4'd4, 32'd100,      32'd0,  1'b0, 6'b100100};
        tbl[3]  = '{1'b1, 4'd3, 32'd5,        32'd0,  1'b0, 6'b100100};
        tbl[4]  = '{1'b1, 4'd5, 32'h1234,     32'd0,  1'b0, 6'b100001};
        tbl[5]  = '{1'b1, 4'd8, 32'd0,        32'd0,  1'b0, 6'b101000};
        tbl[6]  = '{1'b1, 4'd0, 32'd1,        32'd2,  1'b0, 6'b100000};
        tbl[7]  = '{1'b1, 4'd9, 32'd1,        32'd2,  1'b0, 6'b100000};
        tbl[8]  = '{1'b1, 4'd15, 32'd1,       32'd2,  1'b0, 6'b100000};
        tbl[9]  = '{1'b1, 4'd1, 32'd3,        32'd4,  1'b1, 6'b000000};
        tbl[10] = '{1'b1, 4'd4, 32'd9,        32'd0,  1'b1, 6'b000000};
        tbl[11] = '{1'b1, 4'd7, 32'd0,        32'd0,  1'b1, 6'b000000};
        tbl[12] = '{1'b1, 4'd3, 32'd10,       32'd3,  1'b0, 6'b110010};
        tbl[13] = '{1'b1, 4'd6, 32'h55,       32'd0,  1'b1, 6'b000000};
        tbl[14] = '{1'b1, 4'd4, 32'hFFFFFFFF, 32'd16, 1'b0, 6'b110010};

        m_busy = 0; m_issued = 0; m_isdiv = 0; stuck = 0; m_bcnt = 0; rem = 0; lat = 1;
        m_mul = 0; m_div = 0; m_hi = 0; m_lo = 0;
        clr_obs();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_ctl", 64'(o_ctl), 64'(7'b1000000));
        chk("rst_cnt", {32'd0, bus.mul_cnt_o, bus.div_cnt_o}, 64'd0);

        // Divide by zero: dz pulse only
        drive(1'b1, 4'd4, 32'd100, 32'd0, 1'b0);
        tick();
        chk("dz_ctl", 64'(o_ctl), 64'(7'b1001000));
        drain();
        chk("dz_divcnt", 64'(bus.div_cnt_o), 64'd0);

        // MULT 7 * -3, five BUSY cycles, then MFLO
        clr_obs(); lat = 5;
        drive(1'b1, 4'd1, 32'd7, 32'hFFFFFFFD, 1'b0);
        tick();
        drain();
        chk("mult_starts", 64'(o_start), 64'd1);
        chk("mult_stall", 64'(o_stall), 64'd6);
        chk("mult_cnt", 64'(bus.mul_cnt_o), 64'd1);
        drive(1'b1, 4'd8, 32'd0, 32'd0, 1'b0);
        tick();
        chk("mflo_data", {31'd0, o_mfv, o_mfd}, {31'd0, 1'b1, 32'hFFFFFFEB});
        drain();

        // DIV flushed in its third BUSY cycle
        clr_obs(); lat = 10; d0 = m_div;
        drive(1'b1, 4'd3, 32'd50, 32'd7, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        tick(); tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        tick();
        chk("div_flush_rb", 64'(o_ctl[0]), 64'd1);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        tick();
        chk("div_flush_idle", 64'(o_ctl), 64'(7'b1000000));
        chk("div_flush_rbs", 64'(o_rb), 64'd1);
        chk("div_flush_cnt", 64'(bus.div_cnt_o), 64'(d0));

        // MTHI then flush: u_we then rollback
        clr_obs();
        drive(1'b1, 4'd5, 32'h1234, 32'd0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        tick();
        tick();
        chk("mthi_we_rb", {o_we, o_rb}, {32'd1, 32'd1});
        drain();

        // MFHI held across a busy MULT
        lat = 4;
        drive(1'b1, 4'd2, 32'h10000, 32'h30000, 1'b0);
        tick();
        drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
        n = 0;
        do begin tick(); n++; end while (!o_mfv && n < 20);
        chk("mfhi_wait", 64'(n), 64'd5);
        chk("mfhi_data", 64'(o_mfd), 64'h3);
        drain();

        // Directed table
        lat = 2;
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].f);
            tick();
            chk($sformatf("tbl%0d", i), 64'(o_ctl[6:1]), 64'(tbl[i].exp));
            drain();
        end

        // Reset while BUSY: no rollback, nothing counted
        clr_obs(); lat = 8;
        drive(1'b1, 4'd1, 32'd2, 32'd3, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("rst_busy_rb", 64'(o_rb), 64'd0);
        chk("rst_busy_cnt", {32'd0, bus.mul_cnt_o, bus.div_cnt_o}, 64'd0);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            lat = ($urandom_range(0, 15) == 0) ? 40 : int'($urandom_range(1, 6));
            drive($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                  $urandom_range(0, 7) == 0);
            tick();
        end
        drain();

        // Stuck unit: watchdog fires after 32 BUSY cycles
        clr_obs(); stuck = 1'b1;
        drive(1'b1, 4'd2, 32'd5, 32'd6, 1'b0);
        tick();
        drain();
        chk("wd_rb", 64'(o_rb), 64'd1);
        chk("wd_stall", 64'(o_stall), 64'd33);
        stuck = 1'b0;
        tick();

        // Counter saturation from 0xFFFE
        force dut.mul_cnt_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.mul_cnt_q;
        m_mul = 16'hFFFE; lat = 1;
        for (int j = 0; j < 2; j++) begin
            drive(1'b1, 4'd1, 32'd3, 32'd3, 1'b0);
            tick();
            drain();
            chk("mul_sat", 64'(bus.mul_cnt_o), 64'hFFFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-002 SHALL have ports: valid_i in 1, request present; op_i in 4, 1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO 7=MFHI 8=MFLO, other values=no-op; a_i/b_i in 32, rs/rt operands; flush_i in 1, cancel most recent op.
REQ-003 SHALL have ports: ready_o out 1, request accepted this cycle; stall_o out 1, hold requester; mf_valid_o out 1, mf_data_o out 32, move-from result; dz_o out 1, divide-by-zero pulse; mul_cnt_o/div_cnt_o out 16, completed-op counters.
REQ-004 SHALL have unit-side ports: u_a/u_b out 32; u_op out 2, 0=mulu 1=mul 2=divu 3=div, bit0 selects HI for MT/MF; u_start, u_we, u_rollback out 1; u_rd in 32; u_busy in 1.

Function
REQ-005 SHALL implement states IDLE and BUSY; ready_o=1 only in IDLE with flush_i=0.
REQ-006 In IDLE, valid_i with op 1-4 (div with b_i!=0) SHALL assert u_start for exactly that cycle, drive u_a=a_i, u_b=b_i, mapped u_op, set stall_o=1, go BUSY next cycle.
REQ-007 Op 3/4 with b_i==0 SHALL not assert u_start, SHALL pulse dz_o one cycle, stay IDLE, ready_o=1.
REQ-008 MTHI/MTLO in IDLE SHALL assert u_we one cycle with u_a=a_i, u_op[0]=1 for HI, 0 for LO; no stall.
REQ-009 MFHI/MFLO in IDLE SHALL drive u_op[0] accordingly and assert mf_valid_o with mf_data_o=u_rd combinationally the same cycle; no stall.
REQ-010 In BUSY any valid_i SHALL yield ready_o=0, stall_o=1, no unit strobes; requester holds op until accepted.
REQ-011 BUSY SHALL return to IDLE in the first cycle u_busy==0 as sampled at clock edge, with BUSY lasting at least one cycle; the completing op SHALL increment mul_cnt_o (ops 1-2) or div_cnt_o (ops 3-4), saturating at 16'hFFFF.
REQ-012 stall_o SHALL equal (state==BUSY) OR (IDLE issue cycle of op 1-4 with nonzero divisor for div).
REQ-013 flush_i in the cycle after an issue (u_start or u_we) or in any BUSY cycle SHALL assert u_rollback for exactly one cycle and force IDLE next cycle; cancelled op SHALL not increment counters.
REQ-014 flush_i coincident with valid_i SHALL suppress that request: no u_start, u_we, dz_o or mf_valid_o.
REQ-015 flush_i with no issue in previous cycle and state IDLE SHALL produce no u_rollback.
REQ-016 No-op op_i codes SHALL be accepted (ready_o=1) with no unit strobes.
REQ-017 u_start, u_we, u_rollback SHALL never be asserted in the same cycle as each other.
REQ-018 Watchdog: BUSY lasting 32 cycles SHALL force IDLE and pulse u_rollback once.

Reset
REQ-019 reset SHALL force IDLE, clear both counters and the issue-tracking flag; during and after reset cycle all strobes, dz_o, mf_valid_o, stall_o =0, ready_o=1 once reset is low.
REQ-020 reset mid-BUSY SHALL abandon the op without u_rollback and without counting.

Verification
REQ-021 MULT a=7,b=-3 with unit busy 5 cycles -> u_start 1 cycle, u_op=1, stall_o high 6 cycles, mul_cnt_o=1, MFLO then returns u_rd=0xFFFFFFEB.
REQ-022 DIVU a=100,b=0 -> dz_o pulse, no u_start, ready_o=1, div_cnt_o=0.
REQ-023 DIV issued, flush_i third BUSY cycle -> u_rollback one cycle, IDLE next, div_cnt_o unchanged.
REQ-024 MTHI a=0x1234 then flush_i next cycle -> u_we one cycle then u_rollback one cycle.
REQ-025 MFHI held during BUSY -> ready_o=0 until u_busy falls, then mf_valid_o=1 next IDLE cycle.
REQ-026 u_busy stuck high -> after 32 BUSY cycles u_rollback pulse, state IDLE; mul_cnt_o at 0xFFFF plus MULT -> stays 0xFFFF.
